div100_tick_gen: RTL

DIV100_TICK_GEN -- requirements
Module: div100_tick_gen

---
 rtl/div_pkg.sv | 23 ++
 rtl/sync2.sv | 23 ++
 rtl/div100_tick_gen.sv | 90 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divide-by-N tick generator.
package div_pkg;

    localparam int COUNT_W        = 7;
    localparam int DEF_DIVISOR    = 100;
    localparam int DEF_HIGH_START = 50;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } state_e;

    // Two-digit BCD of a count value; {tens, units}. Only valid for v <= 99.
    function automatic logic [7:0] to_bcd(input logic [COUNT_W-1:0] v);
        logic [COUNT_W-1:0] t;
        logic [COUNT_W-1:0] u;
        t = v / COUNT_W'(10);
        u = v - t * COUNT_W'(10);
        return {4'(t), 4'(u)};
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; reset value selectable.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/div100_tick_gen.sv
// Divide-by-DIVISOR counter with square-wave, wrap tick and HOLD/ALIGN/RUN control.
// Define DIV100_BCD_EN to get registered BCD copies of count (requires DIVISOR <= 100).
module div100_tick_gen
    import div_pkg::*;
#(
    parameter int DIVISOR    = DEF_DIVISOR,
    parameter int HIGH_START = DEF_HIGH_START
) (
    input  logic               clk100,
    input  logic               resetn,
    input  logic               enablen,
    input  logic               sync_clr,
    output logic [COUNT_W-1:0] count,
    output logic               out_count7NR,
    output logic               tick,
    output logic               running,
    output logic [3:0]         bcd_tens,
    output logic [3:0]         bcd_units
);

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(DIVISOR - 1);
    localparam logic [COUNT_W-1:0] HI   = COUNT_W'(HIGH_START);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] count_d;
    logic               tick_d;
    logic               high_d;
    logic               en_sync;

    sync2 #(.RST_VAL(1'b1)) u_en_sync (
        .clk   (clk100),
        .rst_n (resetn),
        .d     (enablen),
        .q     (en_sync)
    );

    // sync_clr only zeroes the datapath; the FSM keeps following enablen.
    always_comb begin
        state_d = state_q;
        count_d = '0;
        case (state_q)
            HOLD:    if (!en_sync) state_d = ALIGN;
            ALIGN:   state_d = en_sync ? HOLD : RUN;
            RUN: begin
                if (en_sync) state_d = HOLD;
                else         count_d = (count == LAST) ? '0 : count + 1'b1;
            end
            default: state_d = HOLD;
        endcase
        if (sync_clr) count_d = '0;
        tick_d = (state_d == RUN) && (count_d == LAST);
        high_d = (state_d == RUN) && (count_d >= HI);
    end

    // Outputs are registered from next-state values so they align with count.
    always_ff @(posedge clk100 or negedge resetn) begin
        if (!resetn) begin
            state_q      <= HOLD;
            count        <= '0;
            tick         <= 1'b0;
            out_count7NR <= 1'b0;
            running      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count        <= count_d;
            tick         <= tick_d;
            out_count7NR <= high_d;
            running      <= (state_d == RUN);
        end
    end

`ifdef DIV100_BCD_EN
    logic [7:0] bcd_d;
    assign bcd_d = to_bcd(count_d);

    always_ff @(posedge clk100 or negedge resetn) begin
        if (!resetn) begin
            bcd_tens  <= '0;
            bcd_units <= '0;
        end else begin
            bcd_tens  <= bcd_d[7:4];
            bcd_units <= bcd_d[3:0];
        end
    end
`else
    assign bcd_tens  = '0;
    assign bcd_units = '0;
`endif

endmodule
